reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular reorder buffer (ROB) for the Tomasulo core.
- Allocates the rename tags that ID writes into regfile tags[], and tracks in-flight results from the CDB.
- Commits results in program order to the register file; serves dispatch operand lookups by tag.
- Flushes the pipeline when a mispredicted branch retires.

Parameters:
- TAG_W, 4, tag width; DEPTH = 2**TAG_W entries (16).
- DATA_W, 32, result / PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; when low, no state update.
- alloc_valid  in  1  ID requests one entry.
- alloc_dest_valid  in  1  instruction writes rd.
- alloc_dest_addr  in  5  rd.
- alloc_is_branch  in  1  entry is a branch/jump.
- alloc_tag  out  TAG_W  tag assigned (= tail); combinational.
- rob_full  out  1  combinational, count==DEPTH.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  TAG_W  producing entry.
- cdb_data  in  DATA_W  result.
- cdb_mispredict  in  1  branch outcome differs from prediction.
- cdb_target  in  DATA_W  correct PC for a mispredicted branch.
- q1_tag, q2_tag  in  TAG_W  dispatch lookup tags.
- q1_ready, q2_ready  out  1  entry holds its result; combinational.
- q1_data, q2_data  out  DATA_W  that result; 0 when not ready.
- commit_valid  out  1  registered one-cycle pulse: write regfile.
- commit_addr  out  5  rd.
- commit_data  out  DATA_W  value.
- commit_tag  out  TAG_W  tag of the retiring entry; regfile clears busy only if tags[rd] matches.
- flush  out  1  registered one-cycle pulse.
- flush_pc  out  DATA_W  restart PC.

Behaviour:
- State:
  - head, tail: TAG_W bits each, wrap modulo DEPTH.
  - count: TAG_W+1 bits.
  - Per entry: busy, ready, dest_valid, dest_addr, is_branch, mispredict, data, target.
- Reset (rst at posedge):
  - head=tail=count=0; all busy/ready=0.
  - commit_valid=0, commit_addr=0, commit_data=0, commit_tag=0.
  - flush=0, flush_pc=0.
- Alloc: accepted at an edge when rdy && alloc_valid && !rob_full && !flush-event.
  - Writes entry[tail] with busy=1, ready=0.
  - tail+1, count+1.
  - alloc_valid while full is dropped; ID must stall on rob_full.
- CDB write: at an edge with rdy && cdb_valid && entry[cdb_tag].busy:
  - Set ready, data, mispredict, target.
  - CDB to a non-busy entry is ignored.
- Commit: at an edge with rdy && count!=0 && entry[head].ready:
  - Pop head (busy=0, head+1, count-1).
  - Register commit_valid = entry.dest_valid, together with addr/data/tag.
  - Otherwise commit_valid=0.
  - At most one commit per cycle.
- Latency: CDB sampled at edge E → entry ready after E → popped at E+1 → commit_* visible for the cycle after E+1.
- Simultaneous alloc + commit: count unchanged, both pointers advance.
- Full buffer with a same-edge commit: alloc still refused (rob_full is combinational on the pre-edge count).
- CDB for head at edge E does not commit at E; the earliest commit is E+1.
- Flush event: the committing entry has is_branch && mispredict.
  - flush=1, flush_pc=target.
  - All busy/ready cleared; head=tail=count=0.
  - Same-edge alloc and CDB are discarded.
  - commit_valid still reflects the branch's own dest_valid (JAL/JALR link write).
- Lookup: qN_ready = entry[qN_tag].busy && entry[qN_tag].ready; qN_data = entry data, else 0.
- rdy low: commit_valid and flush cleared to 0 at the edge; all other state held.
- rst mid-operation overrides everything, including a pending flush.

Optional Feature:
- Macro: ROB_BYPASS_EN.
- Defined: lookup also matches the same-cycle CDB. If cdb_valid && cdb_tag==qN_tag && entry busy, then qN_ready=1 and qN_data=cdb_data. This saves one dispatch cycle.
- Undefined: lookup sees only registered entry state.

Decomposition:
- cpu_define.v:
  - `TagBus, `RobDepth, `DataBus, `RegBus.
  - `Valid / `Invalid / `Null.
- Sub-module rob_query: one combinational lookup port, bypass logic included, instantiated twice (q1, q2).

Test Plan:
1. Reset, then 16 allocs with no CDB → tags 0..15, rob_full=1 after the 16th; 17th alloc_tag stays 0 and count stays 16.
2. Alloc tag0 (rd=5), CDB tag0 data 0xDEADBEEF at edge E → commit_valid=1, commit_addr=5, commit_data=0xDEADBEEF, commit_tag=0 in the cycle after E+1.
3. Out-of-order: CDB tag1 then tag0 → commits appear in order tag0, tag1 on consecutive cycles.
4. Branch at tag2 (rd invalid), CDB mispredict target 0x1000 → on commit, flush=1, flush_pc=0x1000, commit_valid=0; next alloc_tag=0, rob_full=0.
5. Wrap and bypass:
   - Wrap: with head=15, retire 15 then 0 → head wraps to 0.
   - Bypass: q1_tag=3 with CDB tag3 data 7 in the same cycle → q1_ready=1, q1_data=7 with ROB_BYPASS_EN; q1_ready=0 without it.
6. rdy=0 for 3 cycles with a ready head → no commit; commit occurs in the cycle after rdy returns high.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
package reorder_buffer_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Per-entry control bits; result data and branch target live in separate arrays.
    typedef struct packed {
        logic      dest_valid;
        reg_addr_t dest_addr;
        logic      is_branch;
        logic      mispredict;
    } rob_ctrl_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Pipeline-facing bus of the reorder buffer: alloc, CDB, lookup, commit and flush.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              rdy;
    logic              alloc_valid;
    logic              alloc_dest_valid;
    reg_addr_t         alloc_dest_addr;
    logic              alloc_is_branch;
    logic [TAG_W-1:0]  alloc_tag;
    logic              rob_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_mispredict;
    logic [DATA_W-1:0] cdb_target;
    logic [TAG_W-1:0]  q1_tag;
    logic [TAG_W-1:0]  q2_tag;
    logic              q1_ready;
    logic              q2_ready;
    logic [DATA_W-1:0] q1_data;
    logic [DATA_W-1:0] q2_data;
    logic              commit_valid;
    reg_addr_t         commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic              flush;
    logic [DATA_W-1:0] flush_pc;

    modport master (
        output rdy, alloc_valid, alloc_dest_valid, alloc_dest_addr, alloc_is_branch,
               cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target, q1_tag, q2_tag,
        input  alloc_tag, rob_full, q1_ready, q2_ready, q1_data, q2_data,
               commit_valid, commit_addr, commit_data, commit_tag, flush, flush_pc
    );

    modport slave (
        input  rdy, alloc_valid, alloc_dest_valid, alloc_dest_addr, alloc_is_branch,
               cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target, q1_tag, q2_tag,
        output alloc_tag, rob_full, q1_ready, q2_ready, q1_data, q2_data,
               commit_valid, commit_addr, commit_data, commit_tag, flush, flush_pc
    );

endinterface

// File: rtl/reorder_buffer_rob_query.sv
// One combinational dispatch lookup port; ROB_BYPASS_EN adds same-cycle CDB forwarding.
module reorder_buffer_rob_query #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic [TAG_W-1:0]  q_tag,
    input  logic              busy  [2**TAG_W],
    input  logic              ready [2**TAG_W],
    input  logic [DATA_W-1:0] data  [2**TAG_W],
`ifdef ROB_BYPASS_EN
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
`endif
    output logic              q_ready,
    output logic [DATA_W-1:0] q_data
);

    always_comb begin
        q_ready = busy[q_tag] && ready[q_tag];
        q_data  = q_ready ? data[q_tag] : '0;
`ifdef ROB_BYPASS_EN
        if (cdb_valid && cdb_tag == q_tag && busy[q_tag]) begin
            q_ready = 1'b1;
            q_data  = cdb_data;
        end
`endif
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB capture, in-order commit and mispredict flush.
// Optional macro ROB_BYPASS_EN forwards the same-cycle CDB result to dispatch lookups.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave bus
);

    localparam int DEPTH = 2**TAG_W;
    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              busy   [DEPTH];
    logic              ready  [DEPTH];
    logic [DATA_W-1:0] data   [DEPTH];
    logic [DATA_W-1:0] target [DEPTH];
    rob_ctrl_t         ctrl   [DEPTH];

    logic              commit_valid_q, flush_q;
    reg_addr_t         commit_addr_q;
    logic [DATA_W-1:0] commit_data_q, flush_pc_q;
    logic [TAG_W-1:0]  commit_tag_q;

    logic full, commit_fire, flush_ev, alloc_fire, cdb_fire;

    assign full        = (count == CNT_W'(DEPTH));
    assign commit_fire = bus.rdy && (count != '0) && ready[head];
    assign flush_ev    = commit_fire && ctrl[head].is_branch && ctrl[head].mispredict;
    assign alloc_fire  = bus.rdy && bus.alloc_valid && !full && !flush_ev;
    assign cdb_fire    = bus.rdy && bus.cdb_valid && busy[bus.cdb_tag] && !flush_ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                busy[i]  <= INVALID;
                ready[i] <= INVALID;
            end
            commit_valid_q <= 1'b0;
            commit_addr_q  <= '0;
            commit_data_q  <= '0;
            commit_tag_q   <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (!bus.rdy) begin
            commit_valid_q <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            commit_valid_q <= commit_fire && ctrl[head].dest_valid;
            if (commit_fire) begin
                commit_addr_q <= ctrl[head].dest_addr;
                commit_data_q <= data[head];
                commit_tag_q  <= head;
            end
            flush_q <= flush_ev;
            if (flush_ev) begin
                flush_pc_q <= target[head];
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    busy[i]  <= INVALID;
                    ready[i] <= INVALID;
                end
            end else begin
                if (cdb_fire) begin
                    ready[bus.cdb_tag]           <= VALID;
                    data[bus.cdb_tag]            <= bus.cdb_data;
                    target[bus.cdb_tag]          <= bus.cdb_target;
                    ctrl[bus.cdb_tag].mispredict <= bus.cdb_mispredict;
                end
                if (alloc_fire) begin
                    busy[tail]  <= VALID;
                    ready[tail] <= INVALID;
                    ctrl[tail]  <= '{dest_valid: bus.alloc_dest_valid,
                                     dest_addr:  bus.alloc_dest_addr,
                                     is_branch:  bus.alloc_is_branch,
                                     mispredict: INVALID};
                    tail <= tail + TAG_W'(1);
                end
                // Pop last so a popped head never keeps a stale ready bit.
                if (commit_fire) begin
                    busy[head]  <= INVALID;
                    ready[head] <= INVALID;
                    head <= head + TAG_W'(1);
                end
                count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
            end
        end
    end

    assign bus.alloc_tag    = tail;
    assign bus.rob_full     = full;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_addr  = commit_addr_q;
    assign bus.commit_data  = commit_data_q;
    assign bus.commit_tag   = commit_tag_q;
    assign bus.flush        = flush_q;
    assign bus.flush_pc     = flush_pc_q;

    reorder_buffer_rob_query #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_q1 (
        .q_tag     (bus.q1_tag),
        .busy      (busy),
        .ready     (ready),
        .data      (data),
`ifdef ROB_BYPASS_EN
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .cdb_data  (bus.cdb_data),
`endif
        .q_ready   (bus.q1_ready),
        .q_data    (bus.q1_data)
    );

    reorder_buffer_rob_query #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_q2 (
        .q_tag     (bus.q2_tag),
        .busy      (busy),
        .ready     (ready),
        .data      (data),
`ifdef ROB_BYPASS_EN
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .cdb_data  (bus.cdb_data),
`endif
        .q_ready   (bus.q2_ready),
        .q_data    (bus.q2_data)
    );

endmodule
